// File: rtl/gfx_pkg.sv
// rtl/gfx_pkg.sv - shared layer-word field positions, backdrop address and fetch FSM states
package gfx_pkg;

    localparam int OPAQUE_BIT  = 15;
    localparam int OBJ_SEL_BIT = 16;
    localparam int IDX_MSB     = 7;

    localparam logic [8:0] BACKDROP_ADDR = 9'h000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        F0   = 2'd1,
        F1   = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/layer_pal_addr.sv
// rtl/layer_pal_addr.sv - combinational layer word to palette address mapping
module layer_pal_addr
    import gfx_pkg::*;
#(
    parameter int LAYER_W = 20,
    parameter int PAL_AW  = 9
) (
    input  logic [LAYER_W-1:0] layer,
    output logic [PAL_AW-1:0]  addr
);

    // Priority and spare bits only travel with the pixel; they never select a colour.
    logic unused_bits;
    assign unused_bits = ^{layer[LAYER_W-1:OBJ_SEL_BIT+1], layer[OPAQUE_BIT-1:IDX_MSB+1]};

    assign addr = layer[OPAQUE_BIT] ? PAL_AW'({layer[OBJ_SEL_BIT], layer[IDX_MSB:0]})
                                    : PAL_AW'(BACKDROP_ADDR);

endmodule

// File: rtl/palette_fetch.sv
// rtl/palette_fetch.sv - two-layer palette colour fetch stage; PAL_SAME_ADDR_SKIP_EN enables single-read pixels
module palette_fetch
    import gfx_pkg::*;
#(
    parameter int LAYER_W = 20,
    parameter int PAL_AW  = 9
) (
    input  logic               clock,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LAYER_W-1:0] in_layer0,
    input  logic [LAYER_W-1:0] in_layer1,
    output logic               pal_re,
    output logic [PAL_AW-1:0]  pal_addr,
    input  logic [15:0]        pal_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LAYER_W-1:0] out_layer0,
    output logic [LAYER_W-1:0] out_layer1,
    output logic [14:0]        out_color0,
    output logic [14:0]        out_color1
);

    fetch_state_t state, next_state;

    logic [LAYER_W-1:0] layer0_q, layer1_q;
    logic [PAL_AW-1:0]  addr0_in, addr1_in, addr1_q;
    logic [14:0]        c0_q, c1_q, c0_d, c1_d;
    logic [14:0]        done_c0, done_c1, load_c0, load_c1;
    logic [14:0]        rd_color;
    logic               out_free, try_accept, accept, complete, load;
    logic               unused_rdata;

    assign rd_color     = pal_rdata[14:0];
    assign unused_rdata = pal_rdata[15];
    assign out_free     = !out_valid || out_ready;

    layer_pal_addr #(.LAYER_W(LAYER_W), .PAL_AW(PAL_AW)) u_addr0 (
        .layer (in_layer0),
        .addr  (addr0_in)
    );

    layer_pal_addr #(.LAYER_W(LAYER_W), .PAL_AW(PAL_AW)) u_addr1 (
        .layer (in_layer1),
        .addr  (addr1_in)
    );

`ifdef PAL_SAME_ADDR_SKIP_EN
    logic skip_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            skip_q <= 1'b0;
        end else if (accept) begin
            skip_q <= (addr0_in == addr1_in);
        end
    end
`endif

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        pal_re     = 1'b0;
        pal_addr   = '0;
        accept     = 1'b0;
        try_accept = 1'b0;
        complete   = 1'b0;
        load       = 1'b0;
        done_c0    = c0_q;
        done_c1    = c1_q;
        load_c0    = c0_q;
        load_c1    = c1_q;
        c0_d       = c0_q;
        c1_d       = c1_q;

        case (state)
            IDLE: try_accept = 1'b1;
            F0: begin
`ifdef PAL_SAME_ADDR_SKIP_EN
                if (skip_q) begin
                    complete = 1'b1;
                    done_c0  = rd_color;
                    done_c1  = rd_color;
                end else
`endif
                begin
                    c0_d       = rd_color;
                    pal_re     = 1'b1;
                    pal_addr   = addr1_q;
                    next_state = F1;
                end
            end
            F1: begin
                complete = 1'b1;
                done_c0  = c0_q;
                done_c1  = rd_color;
            end
            HOLD: begin
                if (out_free) begin
                    load       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase

        // A finished pixel either moves straight to the output or parks in the buffers.
        if (complete) begin
            if (out_free) begin
                load       = 1'b1;
                load_c0    = done_c0;
                load_c1    = done_c1;
                try_accept = 1'b1;
                next_state = IDLE;
            end else begin
                c0_d       = done_c0;
                c1_d       = done_c1;
                next_state = HOLD;
            end
        end

        if (try_accept && rst_n) begin
            in_ready = 1'b1;
            if (in_valid) begin
                accept     = 1'b1;
                pal_re     = 1'b1;
                pal_addr   = addr0_in;
                next_state = F0;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            layer0_q   <= '0;
            layer1_q   <= '0;
            addr1_q    <= '0;
            c0_q       <= '0;
            c1_q       <= '0;
            out_valid  <= 1'b0;
            out_layer0 <= '0;
            out_layer1 <= '0;
            out_color0 <= '0;
            out_color1 <= '0;
        end else begin
            state <= next_state;
            c0_q  <= c0_d;
            c1_q  <= c1_d;
            if (accept) begin
                layer0_q <= in_layer0;
                layer1_q <= in_layer1;
                addr1_q  <= addr1_in;
            end
            if (load) begin
                out_valid  <= 1'b1;
                out_layer0 <= layer0_q;
                out_layer1 <= layer1_q;
                out_color0 <= load_c0;
                out_color1 <= load_c1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
